// File: rtl/jacob_double_seq_if.sv
// Bundle for the doubling sequencer: request/result side toward the
// scalar-mult control and the operand/result side toward jacob_double.
interface jacob_double_seq_if #(
  parameter int W  = 256,
  parameter int CW = 8
);
  logic          start;
  logic [CW-1:0] n;
  logic [W-1:0]  p;
  logic [W-1:0]  a;
  logic [W-1:0]  x_in;
  logic [W-1:0]  y_in;
  logic [W-1:0]  z_in;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  x_out;
  logic [W-1:0]  y_out;
  logic [W-1:0]  z_out;
  logic          dbl_en;
  logic [W-1:0]  dbl_p;
  logic [W-1:0]  dbl_a;
  logic [W-1:0]  dbl_x1;
  logic [W-1:0]  dbl_y1;
  logic [W-1:0]  dbl_z1;
  logic [W-1:0]  dbl_x3;
  logic [W-1:0]  dbl_y3;
  logic [W-1:0]  dbl_z3;
  logic          dbl_flag;

  modport master (
    output start, n, p, a, x_in, y_in, z_in,
    input  busy, done, err, x_out, y_out, z_out,
    input  dbl_en, dbl_p, dbl_a, dbl_x1, dbl_y1, dbl_z1,
    output dbl_x3, dbl_y3, dbl_z3, dbl_flag
  );

  modport slave (
    input  start, n, p, a, x_in, y_in, z_in,
    output busy, done, err, x_out, y_out, z_out,
    output dbl_en, dbl_p, dbl_a, dbl_x1, dbl_y1, dbl_z1,
    input  dbl_x3, dbl_y3, dbl_z3, dbl_flag
  );
endinterface

// File: rtl/jacob_double_seq.sv
// Drives an external jacob_double unit n times to form 2^n*P (Jacobian).
// Define DBL_SEQ_TIMEOUT_EN to abort a stalled doubling with err.
module jacob_double_seq #(
  parameter int W       = 256,
  parameter int CW      = 8,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  jacob_double_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  z_q, z_d;
  logic [W-1:0]  xo_q, xo_d;
  logic [W-1:0]  yo_q, yo_d;
  logic [W-1:0]  zo_q, zo_d;

`ifdef DBL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic          err_q, err_d;
`else
  logic [31:0]   unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
`ifdef DBL_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
    tmo_inc = tmo_q + TW'(1);
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          p_d     = bus.p;
          a_d     = bus.a;
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          z_d     = bus.z_in;
          cnt_d   = bus.n;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cnt_q == '0 || z_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef DBL_SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        // a flag landing on the timeout cycle still counts as success
        if (bus.dbl_flag) begin
          x_d     = bus.dbl_x3;
          y_d     = bus.dbl_y3;
          z_d     = bus.dbl_z3;
          cnt_d   = cnt_q - CW'(1);
          state_d = S_CHECK;
        end
`ifdef DBL_SEQ_TIMEOUT_EN
        else if (tmo_inc == TW'(TIMEOUT)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d == S_DONE) begin
      xo_d = x_q;
      yo_d = y_q;
      zo_d = z_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

`ifdef DBL_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.dbl_en = (state_q == S_LAUNCH);
  assign bus.dbl_p  = p_q;
  assign bus.dbl_a  = a_q;
  assign bus.dbl_x1 = x_q;
  assign bus.dbl_y1 = y_q;
  assign bus.dbl_z1 = z_q;
  assign bus.x_out  = xo_q;
  assign bus.y_out  = yo_q;
  assign bus.z_out  = zo_q;

endmodule

// File: tb/tb_jacob_double_seq.sv
// Bench for jacob_double_seq with a behavioural doubling unit mod 29.
// Expected launches/results are queued at start and checked at done.
module tb_jacob_double_seq;
  localparam int W  = 256;
  localparam int CW = 8;
  localparam int TO = 16;

  typedef struct {
    longint x;
    longint y;
    longint z;
  } pt_t;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] a;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jacob_double_seq_if #(.W(W), .CW(CW)) ifc ();

  jacob_double_seq #(.W(W), .CW(CW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  longint mp = 29;
  longint ma = 4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc;
  int done_cyc;
  int done_cnt = 0;
  int dly[8];

  logic         resp_flag = 1'b0;
  logic         inj_flag  = 1'b0;
  logic [W-1:0] rx = '0;
  logic [W-1:0] ry = '0;
  logic [W-1:0] rz = '0;
  logic [W-1:0] got_x, got_y, got_z;
  logic         got_err;

  pt_t exp_res[$];
  pt_t exp_ops[$];
  op_t got_ops[$];

  assign ifc.dbl_flag = resp_flag | inj_flag;
  assign ifc.dbl_x3   = rx;
  assign ifc.dbl_y3   = ry;
  assign ifc.dbl_z3   = rz;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint md(longint v);
    return ((v % mp) + mp) % mp;
  endfunction

  function automatic logic [W-1:0] to_w(longint v);
    logic [W-1:0] r;
    r = '0;
    r[63:0] = v;
    return r;
  endfunction

  function automatic pt_t mk(longint x, longint y, longint z);
    pt_t r;
    r.x = x;
    r.y = y;
    r.z = z;
    return r;
  endfunction

  // dbl-1998-cmo-2 with general a
  function automatic pt_t dbl(pt_t q);
    longint xx, yy, yyyy, zz, s, m;
    pt_t r;
    xx   = md(q.x * q.x);
    yy   = md(q.y * q.y);
    yyyy = md(yy * yy);
    zz   = md(q.z * q.z);
    s    = md(4 * q.x * yy);
    m    = md(3 * xx + ma * md(zz * zz));
    r.x  = md(m * m - 2 * s);
    r.y  = md(m * md(s - r.x) - 8 * yyyy);
    r.z  = md(2 * q.y * q.z);
    return r;
  endfunction

  // behavioural doubling unit; dly[i]==0 withholds launch i's flag
  initial begin
    bit  pend;
    int  rem;
    int  d;
    op_t o;
    pt_t q;
    pend = 0;
    rem  = 0;
    forever begin
      @(negedge clk);
      resp_flag = 1'b0;
      if (ifc.done) done_cnt++;
      if (pend) begin
        rem--;
        if (rem == 0) begin
          resp_flag = 1'b1;
          pend = 0;
        end
      end
      if (ifc.dbl_en) begin
        o.p = ifc.dbl_p;
        o.a = ifc.dbl_a;
        o.x = ifc.dbl_x1;
        o.y = ifc.dbl_y1;
        o.z = ifc.dbl_z1;
        d = (got_ops.size() < 8) ? dly[got_ops.size()] : 4;
        got_ops.push_back(o);
        if (d > 0) begin
          q = mk(longint'(o.x[31:0]), longint'(o.y[31:0]),
                 longint'(o.z[31:0]));
          q = dbl(q);
          rx = to_w(q.x);
          ry = to_w(q.y);
          rz = to_w(q.z);
          pend = 1;
          rem = d;
        end
      end
    end
  end

  task automatic set_dly(input int d0, input int d1, input int d2);
    for (int i = 0; i < 8; i++) dly[i] = 4;
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
  endtask

  task automatic drive_start(input int nn, input pt_t pin, input int lim);
    pt_t q;
    q = pin;
    for (int i = 0; i < lim; i++) begin
      if (q.z == 0) break;
      exp_ops.push_back(q);
      q = dbl(q);
    end
    exp_res.push_back(q);
    got_ops.delete();
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.n     = CW'(nn);
    ifc.p     = to_w(mp);
    ifc.a     = to_w(ma);
    ifc.x_in  = to_w(pin.x);
    ifc.y_in  = to_w(pin.y);
    ifc.z_in  = to_w(pin.z);
    start_cyc = cyc;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (ifc.done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    done_cyc = cyc;
    got_x    = ifc.x_out;
    got_y    = ifc.y_out;
    got_z    = ifc.z_out;
    got_err  = ifc.err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.n = '0;
    ifc.p = '0;
    ifc.a = '0;
    ifc.x_in = '0;
    ifc.y_in = '0;
    ifc.z_in = '0;
    set_dly(4, 4, 4);
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc.busy, ifc.done, ifc.err, ifc.dbl_en} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000",
               {ifc.busy, ifc.done, ifc.err, ifc.dbl_en});
    end
    checks++;
    if ({ifc.x_out, ifc.y_out, ifc.z_out} !== '0) begin
      errors++;
      $display("FAIL reset_out: got nonzero want 0");
    end
    checks++;
    if ({ifc.dbl_p, ifc.dbl_a, ifc.dbl_x1, ifc.dbl_y1, ifc.dbl_z1} !== '0) begin
      errors++;
      $display("FAIL reset_ops: got nonzero want 0");
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit  seen;
    pt_t e;
    set_dly(4, 4, 4);
    drive_start(1, mk(2, 6, 1), 1);
    wait_done(100, seen);
    e = exp_res.pop_front();
    checks++;
    if (!seen || done_cyc - start_cyc != 8) begin
      errors++;
      $display("FAIL n1_latency: got %0d seen=%0d want 8",
               done_cyc - start_cyc, seen);
    end
    checks++;
    if ({got_x, got_y, got_z} !== {to_w(e.x), to_w(e.y), to_w(e.z)}) begin
      errors++;
      $display("FAIL n1_result: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
               got_x[31:0], got_y[31:0], got_z[31:0], e.x, e.y, e.z);
    end
    checks++;
    if (got_err !== 1'b0) begin
      errors++;
      $display("FAIL n1_err: got %b want 0", got_err);
    end
    checks++;
    if (got_ops.size() != 1) begin
      errors++;
      $display("FAIL n1_launches: got %0d want 1", got_ops.size());
    end
    for (int i = 0; i < got_ops.size() && exp_ops.size() > 0; i++) begin
      e = exp_ops.pop_front();
      checks++;
      if ({got_ops[i].p, got_ops[i].a, got_ops[i].x, got_ops[i].y,
           got_ops[i].z} !==
          {to_w(mp), to_w(ma), to_w(e.x), to_w(e.y), to_w(e.z)}) begin
        errors++;
        $display("FAIL n1_op%0d: got (%0d,%0d,%0d) p=%0d a=%0d want (%0d,%0d,%0d)",
                 i, got_ops[i].x[31:0], got_ops[i].y[31:0],
                 got_ops[i].z[31:0], got_ops[i].p[31:0],
                 got_ops[i].a[31:0], e.x, e.y, e.z);
      end
    end
    exp_ops.delete();
    @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      errors++;
      $display("FAIL n1_busy_fall: got busy=%b done=%b want 0 0",
               ifc.busy, ifc.done);
    end
  endtask

  task automatic test_multi();
    bit  seen;
    pt_t e;
    set_dly(4, 4, 4);
    drive_start(3, mk(2, 6, 1), 3);
    wait_done(200, seen);
    e = exp_res.pop_front();
    checks++;
    if (!seen || done_cyc - start_cyc != 20) begin
      errors++;
      $display("FAIL n3_latency: got %0d seen=%0d want 20",
               done_cyc - start_cyc, seen);
    end
    checks++;
    if ({got_x, got_y, got_z} !== {to_w(e.x), to_w(e.y), to_w(e.z)}) begin
      errors++;
      $display("FAIL n3_result: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
               got_x[31:0], got_y[31:0], got_z[31:0], e.x, e.y, e.z);
    end
    checks++;
    if (got_ops.size() != 3) begin
      errors++;
      $display("FAIL n3_launches: got %0d want 3", got_ops.size());
    end
    for (int i = 0; i < got_ops.size() && exp_ops.size() > 0; i++) begin
      e = exp_ops.pop_front();
      checks++;
      if ({got_ops[i].p, got_ops[i].a, got_ops[i].x, got_ops[i].y,
           got_ops[i].z} !==
          {to_w(mp), to_w(ma), to_w(e.x), to_w(e.y), to_w(e.z)}) begin
        errors++;
        $display("FAIL n3_op%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 i, got_ops[i].x[31:0], got_ops[i].y[31:0],
                 got_ops[i].z[31:0], e.x, e.y, e.z);
      end
    end
    exp_ops.delete();
    @(negedge clk);
  endtask

  task automatic test_degenerate();
    bit  seen;
    pt_t e;
    set_dly(4, 4, 4);
    drive_start(0, mk(2, 6, 1), 0);
    wait_done(20, seen);
    e = exp_res.pop_front();
    checks++;
    if (!seen || done_cyc - start_cyc != 2) begin
      errors++;
      $display("FAIL n0_latency: got %0d seen=%0d want 2",
               done_cyc - start_cyc, seen);
    end
    checks++;
    if ({got_x, got_y, got_z} !== {to_w(2), to_w(6), to_w(1)} ||
        e.x != 2) begin
      errors++;
      $display("FAIL n0_result: got (%0d,%0d,%0d) want (2,6,1)",
               got_x[31:0], got_y[31:0], got_z[31:0]);
    end
    checks++;
    if (got_ops.size() != 0) begin
      errors++;
      $display("FAIL n0_launches: got %0d want 0", got_ops.size());
    end
    exp_ops.delete();
    @(negedge clk);
    drive_start(5, mk(2, 6, 0), 5);
    wait_done(20, seen);
    e = exp_res.pop_front();
    checks++;
    if (!seen || done_cyc - start_cyc != 2) begin
      errors++;
      $display("FAIL zinf_latency: got %0d seen=%0d want 2",
               done_cyc - start_cyc, seen);
    end
    checks++;
    if ({got_x, got_y, got_z} !== {to_w(e.x), to_w(e.y), to_w(0)}) begin
      errors++;
      $display("FAIL zinf_result: got (%0d,%0d,%0d) want (%0d,%0d,0)",
               got_x[31:0], got_y[31:0], got_z[31:0], e.x, e.y);
    end
    checks++;
    if (got_ops.size() != 0) begin
      errors++;
      $display("FAIL zinf_launches: got %0d want 0", got_ops.size());
    end
    exp_ops.delete();
    @(negedge clk);
  endtask

  task automatic test_ignore();
    bit  seen;
    pt_t e;
    int  dc;
    set_dly(4, 4, 4);
    drive_start(3, mk(2, 6, 1), 3);
    repeat (2) @(negedge clk);
    ifc.start = 1'b1;
    ifc.n     = CW'(7);
    ifc.x_in  = to_w(9);
    ifc.y_in  = to_w(9);
    ifc.z_in  = to_w(9);
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(200, seen);
    e = exp_res.pop_front();
    checks++;
    if (!seen || done_cyc - start_cyc != 20) begin
      errors++;
      $display("FAIL ign_latency: got %0d seen=%0d want 20",
               done_cyc - start_cyc, seen);
    end
    checks++;
    if ({got_x, got_y, got_z} !== {to_w(e.x), to_w(e.y), to_w(e.z)}) begin
      errors++;
      $display("FAIL ign_result: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
               got_x[31:0], got_y[31:0], got_z[31:0], e.x, e.y, e.z);
    end
    exp_ops.delete();
    repeat (2) @(negedge clk);
    dc = done_cnt;
    inj_flag = 1'b1;
    @(negedge clk);
    inj_flag = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (got_ops.size() != 3 || done_cnt != dc || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle_flag: got launches=%0d dones=%0d busy=%b want 3 %0d 0",
               got_ops.size(), done_cnt, ifc.busy, dc);
    end
    checks++;
    if ({ifc.x_out, ifc.y_out, ifc.z_out} !==
        {to_w(e.x), to_w(e.y), to_w(e.z)}) begin
      errors++;
      $display("FAIL ign_hold: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
               ifc.x_out[31:0], ifc.y_out[31:0], ifc.z_out[31:0],
               e.x, e.y, e.z);
    end
  endtask

  task automatic test_reset_mid();
    bit  seen;
    pt_t e;
    int  dc;
    set_dly(4, 4, 4);
    drive_start(3, mk(2, 6, 1), 3);
    for (int i = 0; i < 100 && got_ops.size() < 2; i++) @(negedge clk);
    checks++;
    if (got_ops.size() != 2) begin
      errors++;
      $display("FAIL rm_reach_iter2: got launches=%0d want 2", got_ops.size());
    end
    dc = done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if ({ifc.busy, ifc.done, ifc.dbl_en} !== 3'b000) begin
      errors++;
      $display("FAIL rm_async: got busy/done/en=%b want 000",
               {ifc.busy, ifc.done, ifc.dbl_en});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != dc || ifc.busy !== 1'b0 || got_ops.size() != 2) begin
      errors++;
      $display("FAIL rm_late_flag: got dones=%0d busy=%b launches=%0d want %0d 0 2",
               done_cnt, ifc.busy, got_ops.size(), dc);
    end
    checks++;
    if ({ifc.x_out, ifc.y_out, ifc.z_out, ifc.dbl_x1, ifc.dbl_p} !== '0) begin
      errors++;
      $display("FAIL rm_zero_out: got x=%0d z=%0d x1=%0d want 0",
               ifc.x_out[31:0], ifc.z_out[31:0], ifc.dbl_x1[31:0]);
    end
    exp_res.delete();
    exp_ops.delete();
    drive_start(1, mk(2, 6, 1), 1);
    wait_done(100, seen);
    e = exp_res.pop_front();
    checks++;
    if (!seen || done_cyc - start_cyc != 8 ||
        {got_x, got_y, got_z} !== {to_w(e.x), to_w(e.y), to_w(e.z)}) begin
      errors++;
      $display("FAIL rm_rerun: got lat=%0d (%0d,%0d,%0d) want 8 (%0d,%0d,%0d)",
               done_cyc - start_cyc, got_x[31:0], got_y[31:0], got_z[31:0],
               e.x, e.y, e.z);
    end
    exp_ops.delete();
    @(negedge clk);
  endtask

`ifdef DBL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit  seen;
    pt_t e;
    set_dly(4, 0, 4);
    drive_start(3, mk(2, 6, 1), 1);
    wait_done(200, seen);
    e = exp_res.pop_front();
    checks++;
    if (!seen || done_cyc - start_cyc != 25 || got_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_abort: got lat=%0d err=%b want 25 1",
               done_cyc - start_cyc, got_err);
    end
    checks++;
    if ({got_x, got_y, got_z} !== {to_w(e.x), to_w(e.y), to_w(e.z)} ||
        got_ops.size() != 2) begin
      errors++;
      $display("FAIL tmo_point: got (%0d,%0d,%0d) n=%0d want (%0d,%0d,%0d) 2",
               got_x[31:0], got_y[31:0], got_z[31:0], got_ops.size(),
               e.x, e.y, e.z);
    end
    exp_ops.delete();
    @(negedge clk);
    checks++;
    if (ifc.err !== 1'b0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err_pulse: got err=%b busy=%b want 0 0",
               ifc.err, ifc.busy);
    end
    set_dly(4, 16, 4);
    drive_start(3, mk(2, 6, 1), 3);
    wait_done(200, seen);
    e = exp_res.pop_front();
    checks++;
    if (!seen || done_cyc - start_cyc != 32 || got_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_edge: got lat=%0d err=%b want 32 0",
               done_cyc - start_cyc, got_err);
    end
    checks++;
    if ({got_x, got_y, got_z} !== {to_w(e.x), to_w(e.y), to_w(e.z)}) begin
      errors++;
      $display("FAIL tmo_edge_result: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
               got_x[31:0], got_y[31:0], got_z[31:0], e.x, e.y, e.z);
    end
    exp_ops.delete();
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_degenerate();
    test_ignore();
    test_reset_mid();
`ifdef DBL_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
